// File: rtl/mb_rtu_pkg.sv
// mb_rtu_pkg: shared Modbus RTU frame-state encoding and silence-threshold defaults.
package mb_rtu_pkg;
  typedef enum logic [2:0] {ST_SYNC, ST_IDLE, ST_RECV, ST_GAP, ST_HOLD, ST_DISCARD} rtu_state_e;
  localparam int T15_BITS_DEF = 15;
  localparam int T35_BITS_DEF = 35;
endpackage

// File: rtl/mb_silence_timer.sv
// mb_silence_timer: counts line silence in bit times, saturating at T35_BITS.
module mb_silence_timer
  import mb_rtu_pkg::*;
#(
  parameter int BPS_PARAM = 5208,
  parameter int T15_BITS  = T15_BITS_DEF,
  parameter int T35_BITS  = T35_BITS_DEF
) (
  input  logic clk_in,
  input  logic rst_n_in,
  input  logic clear,
  output logic ge_t15,
  output logic ge_t35
);
  localparam int CW = $clog2(BPS_PARAM > 1 ? BPS_PARAM : 2);
  localparam int SW = $clog2(T35_BITS + 1);
  logic [CW-1:0] r_cnt;
  logic [SW-1:0] r_sil;
  logic w_wrap;
  assign w_wrap = r_cnt == CW'(BPS_PARAM - 1);
  always_ff @(posedge clk_in) begin
    if (!rst_n_in || clear) begin
      r_cnt <= '0;
      r_sil <= '0;
    end else begin
      r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;
      if (w_wrap && r_sil != SW'(T35_BITS)) r_sil <= r_sil + 1'b1;
    end
  end
  // activity in this cycle masks any threshold that was already reached
  assign ge_t15 = !clear && r_sil >= SW'(T15_BITS);
  assign ge_t35 = !clear && r_sil >= SW'(T35_BITS);
endmodule

// File: rtl/mb_rtu_frame_ctrl.sv
// mb_rtu_frame_ctrl: Modbus RTU receive-frame sequencer writing bytes into the frame buffer.
module mb_rtu_frame_ctrl
  import mb_rtu_pkg::*;
#(
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD_RATE = 9600,
  parameter int T15_BITS  = T15_BITS_DEF,
  parameter int T35_BITS  = T35_BITS_DEF,
  parameter int MAX_LEN   = 256,
  localparam int LEN_W    = $clog2(MAX_LEN + 1),
  localparam int AW       = $clog2(MAX_LEN)
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             rx_done,
  input  logic [7:0]       rx_data,
  input  logic             rx_state,
  input  logic             frame_ack,
  output logic             buf_wr_en,
  output logic [AW-1:0]    buf_wr_addr,
  output logic [7:0]       buf_wr_data,
  output logic             frame_ready,
  output logic [LEN_W-1:0] frame_len,
  output logic             frame_err,
  output logic             busy
);
  localparam int BPS_PARAM = CLK_FREQ / BAUD_RATE;
  rtu_state_e       r_state;
  logic [LEN_W-1:0] r_len;
  logic             w_ge_t15, w_ge_t35, w_full;

  mb_silence_timer #(
    .BPS_PARAM(BPS_PARAM),
    .T15_BITS (T15_BITS),
    .T35_BITS (T35_BITS)
  ) u_timer (
    .clk_in  (clk_in),
    .rst_n_in(rst_n_in),
    .clear   (rx_state || rx_done),
    .ge_t15  (w_ge_t15),
    .ge_t35  (w_ge_t35)
  );

  assign w_full = r_len == LEN_W'(MAX_LEN);

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      r_state     <= ST_SYNC;
      r_len       <= '0;
      buf_wr_en   <= 1'b0;
      buf_wr_addr <= '0;
      buf_wr_data <= '0;
      frame_ready <= 1'b0;
      frame_len   <= '0;
      frame_err   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      buf_wr_en   <= 1'b0;
      frame_ready <= 1'b0;
      frame_err   <= 1'b0;
      case (r_state)
        ST_SYNC: if (w_ge_t35) r_state <= ST_IDLE;
        // r_len is zero in IDLE, so the first byte shares the RECV write path
        ST_IDLE, ST_RECV:
          if (rx_done && w_full) begin
            frame_err <= 1'b1;
            r_state   <= ST_DISCARD;
          end else if (rx_done) begin
            buf_wr_en   <= 1'b1;
            buf_wr_addr <= r_len[AW-1:0];
            buf_wr_data <= rx_data;
            r_len       <= r_len + 1'b1;
            r_state     <= ST_RECV;
          end else if (r_state == ST_RECV && w_ge_t15) r_state <= ST_GAP;
        ST_GAP:
          if (rx_done) begin
            frame_err <= 1'b1;
            r_state   <= ST_DISCARD;
          end else if (w_ge_t35) begin
            frame_ready <= 1'b1;
            frame_len   <= r_len;
            busy        <= 1'b1;
            r_state     <= ST_HOLD;
          end
        ST_HOLD:
          if (frame_ack) begin
            busy    <= 1'b0;
            r_len   <= '0;
            r_state <= ST_SYNC;
          end
        ST_DISCARD:
          if (w_ge_t35) begin
            r_len   <= '0;
            r_state <= ST_IDLE;
          end
        default: r_state <= ST_SYNC;
      endcase
    end
  end
endmodule

// File: tb/tb_mb_rtu_frame_ctrl.sv
// tb_mb_rtu_frame_ctrl: scoreboard bench for the RTU receive-frame sequencer at 10 clk per bit.
module tb_mb_rtu_frame_ctrl;
  localparam int MAX_LEN = 256;
  localparam int LEN_W = 9;
  localparam int AW = 8;
  localparam int READY_LAT = 351;

  logic clk_in = 0, rst_n_in = 0, rx_done = 0, rx_state = 0, frame_ack = 0;
  logic [7:0] rx_data = 0;
  logic buf_wr_en, frame_ready, frame_err, busy;
  logic [AW-1:0] buf_wr_addr;
  logic [7:0] buf_wr_data;
  logic [LEN_W-1:0] frame_len;
  int checks = 0, failures = 0, quiet = 0;

  typedef enum int {EV_WR, EV_RDY, EV_ERR} ev_kind_e;
  typedef struct {ev_kind_e kind; int val; int data;} ev_t;
  typedef struct {logic [7:0] data; int gap; int exp_addr;} vec_t;
  ev_t exp_q[$];
  vec_t t1[8];
  logic [7:0] f1[8] = '{8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 8'h0A, 8'hC5, 8'hCD};

  mb_rtu_frame_ctrl #(
    .CLK_FREQ (1000),
    .BAUD_RATE(100),
    .T15_BITS (15),
    .T35_BITS (35),
    .MAX_LEN  (MAX_LEN)
  ) dut (
    .clk_in     (clk_in),
    .rst_n_in   (rst_n_in),
    .rx_done    (rx_done),
    .rx_data    (rx_data),
    .rx_state   (rx_state),
    .frame_ack  (frame_ack),
    .buf_wr_en  (buf_wr_en),
    .buf_wr_addr(buf_wr_addr),
    .buf_wr_data(buf_wr_data),
    .frame_ready(frame_ready),
    .frame_len  (frame_len),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  always #5 clk_in = ~clk_in;
  // clock edges since the line was last active
  always @(posedge clk_in) quiet <= (!rst_n_in || rx_done || rx_state) ? 0 : quiet + 1;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  function automatic void push(input ev_kind_e k, input int v, input int d);
    exp_q.push_back('{k, v, d});
  endfunction

  task automatic observe(input ev_kind_e k, input int v, input int d);
    ev_t e;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL unexpected_event: got %s val=%0d data=%0d, expected none at %0t", k.name(), v, d, $time);
    end else begin
      e = exp_q.pop_front();
      check("event_kind", k, e.kind);
      check("event_val", v, e.val);
      check("event_data", d, e.data);
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk_in);
      if (buf_wr_en === 1'b1) observe(EV_WR, int'(buf_wr_addr), int'(buf_wr_data));
      if (frame_ready === 1'b1) begin
        observe(EV_RDY, int'(frame_len), 0);
        check("ready_latency", quiet, READY_LAT);
        check("busy_at_ready", busy, 1);
      end
      if (frame_err === 1'b1) observe(EV_ERR, 0, 0);
    end
  endtask

  task automatic send(input logic [7:0] d);
    @(posedge clk_in);
    #1 rx_done = 1; rx_data = d;
    @(posedge clk_in);
    #1 rx_done = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk_in);
  endtask

  task automatic ack();
    @(posedge clk_in);
    #1 frame_ack = 1;
    @(posedge clk_in);
    #1 frame_ack = 0;
  endtask

  task automatic drain(input string name, input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) @(posedge clk_in);
    check(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic check_zero(input string name);
    check(name, int'({buf_wr_en, buf_wr_addr, buf_wr_data, frame_ready, frame_len, frame_err, busy}), 0);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) t1[i] = '{f1[i], 99, i};
    fork monitor(); join_none
    idle(2);
    @(negedge clk_in);
    check_zero("reset_outputs");
    @(posedge clk_in);
    #1 rst_n_in = 1;
    idle(400);
    // nominal 8-byte frame
    foreach (t1[i]) begin
      push(EV_WR, t1[i].exp_addr, t1[i].data);
      send(t1[i].data);
      idle(t1[i].gap);
    end
    push(EV_RDY, 8, 0);
    drain("frame8_done", 500);
    // bytes during HOLD are dropped while the buffer is owned
    for (int i = 0; i < 3; i++) begin
      send(8'hA0 + 8'(i));
      @(negedge clk_in);
      check("hold_busy", busy, 1);
      check("hold_len", frame_len, 8);
      idle(20);
    end
    ack();
    @(negedge clk_in);
    check("busy_after_ack", busy, 0);
    idle(400);
    push(EV_WR, 0, 8'h11); send(8'h11); idle(30);
    push(EV_WR, 1, 8'h22); send(8'h22);
    push(EV_RDY, 2, 0);
    drain("frame_after_hold", 500);
    ack();
    // 1.5T gap violation, then a byte during DISCARD is silently dropped
    push(EV_WR, 0, 8'h31); send(8'h31); idle(200);
    push(EV_ERR, 0, 0); send(8'h32); idle(100);
    send(8'h33); idle(400);
    push(EV_WR, 0, 8'h34); send(8'h34);
    push(EV_RDY, 1, 0);
    drain("frame_after_gap_err", 500);
    ack();
    // byte lands on the cycle the 3.5T threshold is reached / first visible
    for (int n = 348; n <= 349; n++) begin
      push(EV_WR, 0, 8'h40); send(8'h40); idle(n);
      push(EV_ERR, 0, 0); send(8'h41); idle(400);
    end
    drain("t35_race", 10);
    // overflow: MAX_LEN writes then an error on the extra byte
    for (int i = 0; i <= MAX_LEN; i++) begin
      if (i < MAX_LEN) push(EV_WR, i, int'(8'(i) ^ 8'h5A));
      else push(EV_ERR, 0, 0);
      send(8'(i) ^ 8'h5A);
      idle(3);
    end
    idle(400);
    drain("overflow", 10);
    // reset mid-frame abandons the frame without an error
    push(EV_WR, 0, 8'h51); send(8'h51); idle(10);
    push(EV_WR, 1, 8'h52); send(8'h52); idle(10);
    push(EV_WR, 2, 8'h53); send(8'h53);
    rst_n_in = 0;
    @(posedge clk_in);
    @(negedge clk_in);
    check_zero("midframe_reset_outputs");
    @(posedge clk_in);
    #1 rst_n_in = 1;
    idle(100);
    send(8'h60);
    idle(400);
    push(EV_WR, 0, 8'h61); send(8'h61);
    push(EV_RDY, 1, 0);
    drain("frame_after_reset", 500);
    ack();
    idle(5);
    check("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
